// File: rtl/booth_digit_sequencer.sv
// ---------------------------------------------------------------------------
// booth_digit_sequencer
//
// Purpose:
//   Accepts a WIDTH-bit multiplier operand over a valid/ready handshake and
//   emits its Booth-recoded digits (radix 2^GROUP) one per transfer, LSB
//   group first, as sign + magnitude. Handles signed and unsigned operands
//   and flags the final digit for the partial-product selector/accumulator.
//
// Parameters:
//   WIDTH  operand width (>= GROUP)
//   GROUP  bits retired per digit, legal values 2, 3, 4
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (priority over clear)
//   clear      synchronous abort, discards the current operand
//   in_valid   operand valid
//   in_ready   sequencer can accept an operand (IDLE only)
//   in_data    multiplier operand
//   in_signed  1: two's-complement operand, 0: unsigned
//   dig_valid  digit valid
//   dig_ready  consumer accepts the digit
//   dig_neg    digit is negative (never set for a zero digit)
//   dig_mag    digit magnitude, 0 .. 2^(GROUP-1)
//   dig_idx    digit index, weight 2^(GROUP*dig_idx)
//   dig_last   final digit of the operand
//
// Build option:
//   BOOTH_SEQ_EARLY_TERM_EN  when defined, dig_last is also raised as soon as
//                            every remaining digit would be zero.
// ---------------------------------------------------------------------------
module booth_digit_sequencer #(
  parameter  int WIDTH = 16,
  parameter  int GROUP = 4,
  localparam int NDMAX = (WIDTH + GROUP) / GROUP,
  localparam int IW    = $clog2(NDMAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic             dig_neg,
  output logic [GROUP-1:0] dig_mag,
  output logic [IW-1:0]    dig_idx,
  output logic             dig_last
);

  localparam int EW   = NDMAX * GROUP;
  localparam int ND_S = (WIDTH + GROUP - 1) / GROUP;
  localparam logic [IW-1:0] LAST_S = IW'(ND_S - 1);
  localparam logic [IW-1:0] LAST_U = IW'(NDMAX - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [EW-1:0]  sreg;
  logic           prev;
  logic [IW-1:0]  idx;
  logic           sgn;

  logic           load;
  logic           advance;
  logic           run;
  logic [EW-1:0]  ext;
  logic           fill;
  logic [GROUP-1:0] grp;
  logic [GROUP:0] dval;
  logic [GROUP:0] mag_full;
  logic           last_raw;
  logic           idx_last;

  assign run = (state == RUN);

  // Extension bit of the operand: sign bit for signed operands, zero for
  // unsigned ones. Used both when loading and as the shift fill.
  assign ext  = {{(EW - WIDTH){in_signed & in_data[WIDTH-1]}}, in_data};
  assign fill = sgn & sreg[EW-1];

  // Digit decode from the registered low group and previous bit. The group
  // is read as a GROUP-bit two's-complement number and the previous bit is
  // added; GROUP+1 bits cover the range -2^(G-1) .. +2^(G-1).
  always_comb begin
    grp      = sreg[GROUP-1:0];
    dval     = {grp[GROUP-1], grp} + {{GROUP{1'b0}}, prev};
    mag_full = dval[GROUP] ? (~dval + 1'b1) : dval;
  end

  // Last-digit detection: the index reaching the digit count of the
  // operand's signedness, optionally OR'd with "everything above this group
  // is a copy of the group's top bit", which makes all later digits zero.
  always_comb begin
    idx_last = sgn ? (idx == LAST_S) : (idx == LAST_U);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    if (grp[GROUP-1]) begin
      last_raw = idx_last | (&sreg[EW-1:GROUP]);
    end else begin
      last_raw = idx_last | ~(|sreg[EW-1:GROUP]);
    end
`else
    last_raw = idx_last;
`endif
  end

  // Outputs are gated by the RUN state so IDLE always presents reset values.
  assign dig_neg  = run & dval[GROUP];
  assign dig_mag  = run ? mag_full[GROUP-1:0] : '0;
  assign dig_idx  = run ? idx : '0;
  assign dig_last = run & last_raw;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. clear overrides any handshake in the
  // same cycle, so a concurrent digit transfer or operand load is dropped.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    dig_valid  = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        dig_valid = 1'b1;
        if (dig_ready) begin
          if (last_raw) begin
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
      load       = 1'b0;
      advance    = 1'b0;
    end
  end

  // Operand shift register, previous bit, digit index and signedness.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sreg <= '0;
      prev <= 1'b0;
      idx  <= '0;
      sgn  <= 1'b0;
    end else if (load) begin
      sreg <= ext;
      prev <= 1'b0;
      idx  <= '0;
      sgn  <= in_signed;
    end else if (advance) begin
      sreg <= {{GROUP{fill}}, sreg[EW-1:GROUP]};
      prev <= sreg[GROUP-1];
      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_booth_digit_sequencer
//
// Directed bench for booth_digit_sequencer: a WIDTH=16/GROUP=4 instance and
// a WIDTH=16/GROUP=2 instance. Expected digits are hand-computed Booth
// recodings; BOOTH_SEQ_EARLY_TERM_EN selects the early-termination tables.
// ---------------------------------------------------------------------------
module tb_booth_digit_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clear;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        dig_valid;
  logic        dig_ready;
  logic        dig_neg;
  logic [3:0]  dig_mag;
  logic [2:0]  dig_idx;
  logic        dig_last;

  logic        in_valid_g2;
  logic        in_ready_g2;
  logic [15:0] in_data_g2;
  logic        in_signed_g2;
  logic        dig_valid_g2;
  logic        dig_ready_g2;
  logic        dig_neg_g2;
  logic [1:0]  dig_mag_g2;
  logic [3:0]  dig_idx_g2;
  logic        dig_last_g2;

  int checks   = 0;
  int failures = 0;

  logic [8:0] got4 [0:15];
  logic [8:0] exp4 [0:15];
  logic [7:0] got2 [0:15];
  logic [7:0] exp2 [0:15];
  int         got_n;
  int         en;

  booth_digit_sequencer #(.WIDTH(16), .GROUP(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_neg(dig_neg),
    .dig_mag(dig_mag), .dig_idx(dig_idx), .dig_last(dig_last)
  );

  booth_digit_sequencer #(.WIDTH(16), .GROUP(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid_g2), .in_ready(in_ready_g2), .in_data(in_data_g2), .in_signed(in_signed_g2),
    .dig_valid(dig_valid_g2), .dig_ready(dig_ready_g2), .dig_neg(dig_neg_g2),
    .dig_mag(dig_mag_g2), .dig_idx(dig_idx_g2), .dig_last(dig_last_g2)
  );

  function automatic logic [8:0] mk4(input logic n, input logic [3:0] m, input logic [2:0] i, input logic l);
    return {n, m, i, l};
  endfunction

  function automatic logic [7:0] mk2(input logic n, input logic [1:0] m, input logic [3:0] i, input logic l);
    return {n, m, i, l};
  endfunction

  task automatic send4(input logic [15:0] data, input logic sgn);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL send4_ready: in_ready=%b required 1", in_ready);
    end
    in_valid  = 1'b1;
    in_data   = data;
    in_signed = sgn;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic collect4();
    bit done;
    done      = 1'b0;
    got_n     = 0;
    dig_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (dig_valid) begin
        if (got_n < 16) got4[got_n] = {dig_neg, dig_mag, dig_idx, dig_last};
        got_n++;
        if (dig_last) done = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send2(input logic [15:0] data, input logic sgn);
    int w;
    w = 0;
    while (!in_ready_g2 && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (in_ready_g2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL send2_ready: in_ready=%b required 1", in_ready_g2);
    end
    in_valid_g2  = 1'b1;
    in_data_g2   = data;
    in_signed_g2 = sgn;
    @(posedge clk); #1;
    in_valid_g2  = 1'b0;
  endtask

  task automatic collect2();
    bit done;
    done         = 1'b0;
    got_n        = 0;
    dig_ready_g2 = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (dig_valid_g2) begin
        if (got_n < 16) got2[got_n] = {dig_neg_g2, dig_mag_g2, dig_idx_g2, dig_last_g2};
        got_n++;
        if (dig_last_g2) done = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, dig_valid, dig_neg, dig_mag, dig_idx, dig_last} !== 11'b10_0_0000_000_0) begin
      failures++;
      $display("[TB] FAIL reset_g4: got %b required 10000000000",
               {in_ready, dig_valid, dig_neg, dig_mag, dig_idx, dig_last});
    end
    checks++;
    if ({in_ready_g2, dig_valid_g2, dig_neg_g2, dig_mag_g2, dig_idx_g2, dig_last_g2} !== 10'b10_0_00_0000_0) begin
      failures++;
      $display("[TB] FAIL reset_g2: got %b required 1000000000",
               {in_ready_g2, dig_valid_g2, dig_neg_g2, dig_mag_g2, dig_idx_g2, dig_last_g2});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_00ff();
    logic early;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    early = 1'b1;
    en    = 3;
`else
    early = 1'b0;
    en    = 4;
`endif
    exp4[0] = mk4(1'b1, 4'd1, 3'd0, 1'b0);
    exp4[1] = mk4(1'b0, 4'd0, 3'd1, 1'b0);
    exp4[2] = mk4(1'b0, 4'd1, 3'd2, early);
    exp4[3] = mk4(1'b0, 4'd0, 3'd3, 1'b1);
    send4(16'h00FF, 1'b1);
    collect4();
    checks++;
    if (got_n !== en) begin
      failures++;
      $display("[TB] FAIL s00ff_count: got %0d digits required %0d", got_n, en);
    end
    for (int i = 0; i < en && i < got_n; i++) begin
      checks++;
      if (got4[i] !== exp4[i]) begin
        failures++;
        $display("[TB] FAIL s00ff_digit%0d: got %b required %b", i, got4[i], exp4[i]);
      end
    end
  endtask

  task automatic test_unsigned_ffff();
    en      = 5;
    exp4[0] = mk4(1'b1, 4'd1, 3'd0, 1'b0);
    exp4[1] = mk4(1'b0, 4'd0, 3'd1, 1'b0);
    exp4[2] = mk4(1'b0, 4'd0, 3'd2, 1'b0);
    exp4[3] = mk4(1'b0, 4'd0, 3'd3, 1'b0);
    exp4[4] = mk4(1'b0, 4'd1, 3'd4, 1'b1);
    send4(16'hFFFF, 1'b0);
    collect4();
    checks++;
    if (got_n !== en) begin
      failures++;
      $display("[TB] FAIL uffff_count: got %0d digits required %0d", got_n, en);
    end
    for (int i = 0; i < en && i < got_n; i++) begin
      checks++;
      if (got4[i] !== exp4[i]) begin
        failures++;
        $display("[TB] FAIL uffff_digit%0d: got %b required %b", i, got4[i], exp4[i]);
      end
    end
  endtask

  task automatic test_signed_ffff();
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    en      = 1;
    exp4[0] = mk4(1'b1, 4'd1, 3'd0, 1'b1);
`else
    en      = 4;
    exp4[0] = mk4(1'b1, 4'd1, 3'd0, 1'b0);
    exp4[1] = mk4(1'b0, 4'd0, 3'd1, 1'b0);
    exp4[2] = mk4(1'b0, 4'd0, 3'd2, 1'b0);
    exp4[3] = mk4(1'b0, 4'd0, 3'd3, 1'b1);
`endif
    send4(16'hFFFF, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || dig_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sffff_run: in_ready=%b dig_valid=%b required 0 1", in_ready, dig_valid);
    end
    collect4();
    checks++;
    if (got_n !== en) begin
      failures++;
      $display("[TB] FAIL sffff_count: got %0d digits required %0d", got_n, en);
    end
    for (int i = 0; i < en && i < got_n; i++) begin
      checks++;
      if (got4[i] !== exp4[i]) begin
        failures++;
        $display("[TB] FAIL sffff_digit%0d: got %b required %b", i, got4[i], exp4[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    en      = 1;
    exp4[0] = mk4(1'b0, 4'd1, 3'd0, 1'b1);
`else
    en      = 5;
    exp4[0] = mk4(1'b0, 4'd1, 3'd0, 1'b0);
    exp4[1] = mk4(1'b0, 4'd0, 3'd1, 1'b0);
    exp4[2] = mk4(1'b0, 4'd0, 3'd2, 1'b0);
    exp4[3] = mk4(1'b0, 4'd0, 3'd3, 1'b0);
    exp4[4] = mk4(1'b0, 4'd0, 3'd4, 1'b1);
`endif
    send4(16'h0001, 1'b0);
    collect4();
    checks++;
    if (got_n !== en) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d digits required %0d", got_n, en);
    end
    for (int i = 0; i < en && i < got_n; i++) begin
      checks++;
      if (got4[i] !== exp4[i]) begin
        failures++;
        $display("[TB] FAIL b2b_digit%0d: got %b required %b", i, got4[i], exp4[i]);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_idle: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_signed_8000();
    en      = 4;
    exp4[0] = mk4(1'b0, 4'd0, 3'd0, 1'b0);
    exp4[1] = mk4(1'b0, 4'd0, 3'd1, 1'b0);
    exp4[2] = mk4(1'b0, 4'd0, 3'd2, 1'b0);
    exp4[3] = mk4(1'b1, 4'd8, 3'd3, 1'b1);
    send4(16'h8000, 1'b1);
    collect4();
    checks++;
    if (got_n !== en) begin
      failures++;
      $display("[TB] FAIL s8000_count: got %0d digits required %0d", got_n, en);
    end
    for (int i = 0; i < en && i < got_n; i++) begin
      checks++;
      if (got4[i] !== exp4[i]) begin
        failures++;
        $display("[TB] FAIL s8000_digit%0d: got %b required %b", i, got4[i], exp4[i]);
      end
    end
  endtask

  task automatic test_group2();
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    en      = 2;
    exp2[0] = mk2(1'b1, 2'd1, 4'd0, 1'b0);
    exp2[1] = mk2(1'b0, 2'd1, 4'd1, 1'b1);
`else
    en      = 8;
    exp2[0] = mk2(1'b1, 2'd1, 4'd0, 1'b0);
    exp2[1] = mk2(1'b0, 2'd1, 4'd1, 1'b0);
    for (int i = 2; i < 8; i++) exp2[i] = mk2(1'b0, 2'd0, 4'(i), i == 7);
`endif
    send2(16'h0003, 1'b1);
    collect2();
    checks++;
    if (got_n !== en) begin
      failures++;
      $display("[TB] FAIL g2_count: got %0d digits required %0d", got_n, en);
    end
    for (int i = 0; i < en && i < got_n; i++) begin
      checks++;
      if (got2[i] !== exp2[i]) begin
        failures++;
        $display("[TB] FAIL g2_digit%0d: got %b required %b", i, got2[i], exp2[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic early;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    send4(16'h00FF, 1'b1);
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({dig_valid, dig_neg, dig_mag, dig_idx, dig_last} !== {1'b1, mk4(1'b0, 4'd0, 3'd1, 1'b0)}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got %b required %b", c,
                 {dig_valid, dig_neg, dig_mag, dig_idx, dig_last}, {1'b1, mk4(1'b0, 4'd0, 3'd1, 1'b0)});
      end
    end
    dig_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dig_valid, dig_neg, dig_mag, dig_idx, dig_last} !== {1'b1, mk4(1'b0, 4'd1, 3'd2, early)}) begin
      failures++;
      $display("[TB] FAIL bp_resume: got %b required %b",
               {dig_valid, dig_neg, dig_mag, dig_idx, dig_last}, {1'b1, mk4(1'b0, 4'd1, 3'd2, early)});
    end
    collect4();
    checks++;
    if (got_n !== (early ? 1 : 2)) begin
      failures++;
      $display("[TB] FAIL bp_drain: got %0d digits required %0d", got_n, early ? 1 : 2);
    end
  endtask

  task automatic test_clear();
    send4(16'h00FF, 1'b1);
    dig_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dig_idx !== 3'd2 || dig_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clr_pre: idx=%0d valid=%b required 2 1", dig_idx, dig_valid);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if ({in_ready, dig_valid, dig_idx} !== {1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("[TB] FAIL clr_idle: got %b required 10000", {in_ready, dig_valid, dig_idx});
    end
    send4(16'h8000, 1'b1);
    collect4();
    checks++;
    if (got_n !== 4) begin
      failures++;
      $display("[TB] FAIL clr_next_count: got %0d digits required 4", got_n);
    end
    checks++;
    if (got4[0] !== mk4(1'b0, 4'd0, 3'd0, 1'b0) || got4[3] !== mk4(1'b1, 4'd8, 3'd3, 1'b1)) begin
      failures++;
      $display("[TB] FAIL clr_next_digits: got %b %b required %b %b", got4[0], got4[3],
               mk4(1'b0, 4'd0, 3'd0, 1'b0), mk4(1'b1, 4'd8, 3'd3, 1'b1));
    end
  endtask

  task automatic test_rst_midrun();
    send4(16'hFFFF, 1'b0);
    dig_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dig_idx !== 3'd1 || dig_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_pre: idx=%0d valid=%b required 1 1", dig_idx, dig_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, dig_valid, dig_neg, dig_mag, dig_idx, dig_last} !== 11'b10_0_0000_000_0) begin
      failures++;
      $display("[TB] FAIL rst_mid: got %b required 10000000000",
               {in_ready, dig_valid, dig_neg, dig_mag, dig_idx, dig_last});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_signed    = 1'b0;
    dig_ready    = 1'b0;
    in_valid_g2  = 1'b0;
    in_data_g2   = '0;
    in_signed_g2 = 1'b0;
    dig_ready_g2 = 1'b0;
    test_reset();
    test_signed_00ff();
    test_unsigned_ffff();
    test_signed_ffff();
    test_back_to_back();
    test_signed_8000();
    test_group2();
    test_backpressure();
    test_clear();
    test_rst_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
